// File: rtl/pwm_sched_pkg.sv
// Shared field widths, FSM encoding and defaults for the PWM command scheduler.
package pwm_sched_pkg;

  localparam int unsigned ChW           = 8;
  localparam int unsigned DutyW         = 8;
  localparam int unsigned DessertW      = 16;
  localparam int unsigned PnumW         = 8;
  localparam int unsigned PatW          = 32;
  localparam int unsigned DropW         = 8;
  localparam int unsigned AckTimeoutDef = 15;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitFree,
    StStart,
    StAck
  } state_e;

  typedef struct packed {
    logic [DutyW-1:0]    duty;
    logic [DessertW-1:0] dessert;
    logic [PnumW-1:0]    pnum;
    logic [PatW-1:0]     pat;
  } cfg_t;

  localparam int unsigned CfgW = $bits(cfg_t);

endpackage

// File: rtl/pwm_cmd_fifo.sv
// Synchronous show-ahead command queue with registered full flag and occupancy count.
module pwm_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [Width-1:0]        i_data,
  output logic [Width-1:0]        o_data,
  output logic [$clog2(Depth):0]  o_count,
  output logic                    o_full
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             r_full;
  logic [PtrW:0]    w_count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & (r_count != '0);

  always_comb begin
    w_count_d = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_d = r_count + (PtrW+1)'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_d = r_count - (PtrW+1)'(1);
    end
  end

  // Pointers are PtrW bits wide, so increments wrap modulo Depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == (PtrW+1)'(Depth));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

// File: rtl/pwm_cmd_scheduler.sv
// Queues PWM channel commands and hands them one at a time to the target channel,
// releasing a running channel first and watching for its busy acknowledge.
module pwm_cmd_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int unsigned _NUM_CHANNELS = 4,
  parameter int unsigned _FIFO_DEPTH   = 4,
  parameter int unsigned _ACK_TIMEOUT  = AckTimeoutDef
) (
  input  logic                     i_clk_50M,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  input  logic [ChW-1:0]           i_cmd_ch,
  input  logic [DutyW-1:0]         i_cmd_duty,
  input  logic [DessertW-1:0]      i_cmd_dessert,
  input  logic [PnumW-1:0]         i_cmd_pnum,
  input  logic [PatW-1:0]          i_cmd_pat,
  input  logic                     i_cmd_stop,
  input  logic [_NUM_CHANNELS-1:0] i_pwm_busy,
  input  logic [_NUM_CHANNELS-1:0] i_pwm_valid,
  output logic                     o_cmd_full,
  output logic [_NUM_CHANNELS-1:0] o_pwm_en,
  output logic [DutyW-1:0]         o_cfg_duty,
  output logic [DessertW-1:0]      o_cfg_dessert,
  output logic [PnumW-1:0]         o_cfg_pnum,
  output logic [PatW-1:0]          o_cfg_pat,
  output logic [_NUM_CHANNELS-1:0] o_cfg_sel,
  output logic                     o_err_bad_ch,
  output logic                     o_err_timeout,
  output logic [DropW-1:0]         o_drop_cnt
);

  localparam int unsigned IdxW   = (_NUM_CHANNELS > 1) ? $clog2(_NUM_CHANNELS) : 1;
  localparam int unsigned EntryW = IdxW + CfgW;
  localparam int unsigned TmoW   = $clog2(_ACK_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(_ACK_TIMEOUT - 1);

  state_e                     r_state, w_state_d;
  cfg_t                       r_cfg, w_cmd_cfg, w_head_cfg;
  logic [IdxW-1:0]            r_ch, w_head_ch;
  logic [_NUM_CHANNELS-1:0]   r_pwm_en, w_pwm_en_d;
  logic [_NUM_CHANNELS-1:0]   r_cfg_sel, w_head_sel;
  logic [TmoW-1:0]            r_tmo;
  logic                       r_err_bad_ch, r_err_timeout;
  logic [DropW-1:0]           r_drop_cnt;
  logic [EntryW-1:0]          w_head;
  logic [$clog2(_FIFO_DEPTH):0] w_count;
  logic                       w_full, w_empty, w_ch_ok, w_push, w_pop, w_timeout, w_cmd_live;

  // A stop strobe discards any command arriving in the same cycle.
  assign w_cmd_live = i_cmd_valid & ~i_cmd_stop;
  assign w_ch_ok    = 32'(i_cmd_ch) < _NUM_CHANNELS;
  assign w_push     = w_cmd_live & w_ch_ok & ~w_full;
  assign w_pop      = (r_state == StLoad);
  assign w_empty    = (w_count == '0);
  assign w_cmd_cfg  = {i_cmd_duty, i_cmd_dessert, i_cmd_pnum, i_cmd_pat};
  assign {w_head_ch, w_head_cfg} = w_head;
  assign w_timeout  = (r_state == StAck) & ~i_pwm_busy[r_ch] & (r_tmo == TmoLast);

  pwm_cmd_fifo #(
    .Width (EntryW),
    .Depth (_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk_50M),
    .i_rst   (i_rst),
    .i_flush (i_cmd_stop),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_cmd_ch[IdxW-1:0], w_cmd_cfg}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_comb begin
    w_head_sel = '0;
    w_head_sel[w_head_ch] = 1'b1;
  end

  always_comb begin
    w_state_d  = r_state;
    w_pwm_en_d = r_pwm_en & ~i_pwm_valid;
    unique case (r_state)
      StIdle:     if (!w_empty) w_state_d = StLoad;
      StLoad:     w_state_d = StWaitFree;
      StWaitFree: begin
        w_pwm_en_d[r_ch] = 1'b0;
        if (!i_pwm_busy[r_ch] && !r_pwm_en[r_ch]) w_state_d = StStart;
      end
      StStart: begin
        w_pwm_en_d[r_ch] = 1'b1;
        w_state_d = StAck;
      end
      StAck: begin
        if (i_pwm_busy[r_ch]) begin
          w_state_d = StIdle;
        end else if (w_timeout) begin
          w_pwm_en_d[r_ch] = 1'b0;
          w_state_d = StIdle;
        end
      end
      default:    w_state_d = StIdle;
    endcase
    if (i_cmd_stop) begin
      w_state_d  = StIdle;
      w_pwm_en_d = '0;
    end
  end

  always_ff @(posedge i_clk_50M or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_pwm_en      <= '0;
      r_cfg         <= '0;
      r_ch          <= '0;
      r_cfg_sel     <= '0;
      r_tmo         <= '0;
      r_err_bad_ch  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_pwm_en <= w_pwm_en_d;
      r_tmo    <= (r_state == StAck) ? r_tmo + TmoW'(1) : '0;
      if (r_state == StLoad) begin
        r_cfg     <= w_head_cfg;
        r_ch      <= w_head_ch;
        r_cfg_sel <= w_head_sel;
      end
      if (w_cmd_live && !w_ch_ok) r_err_bad_ch <= 1'b1;
      if (w_cmd_live && w_ch_ok && w_full && r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + DropW'(1);
      end
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign o_cmd_full    = w_full;
  assign o_pwm_en      = r_pwm_en;
  assign o_cfg_duty    = r_cfg.duty;
  assign o_cfg_dessert = r_cfg.dessert;
  assign o_cfg_pnum    = r_cfg.pnum;
  assign o_cfg_pat     = r_cfg.pat;
  assign o_cfg_sel     = r_cfg_sel;
  assign o_err_bad_ch  = r_err_bad_ch;
  assign o_err_timeout = r_err_timeout;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Directed bench for pwm_cmd_scheduler: a cycle table for the basic flow plus
// hand-written sequences for queueing, timeout, restart and stop corner cases.
module tb_pwm_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_ch;
  logic [7:0]  cmd_duty;
  logic [15:0] cmd_dessert;
  logic [7:0]  cmd_pnum;
  logic [31:0] cmd_pat;
  logic        cmd_stop;
  logic [3:0]  pwm_busy;
  logic [3:0]  pwm_valid;
  logic        cmd_full;
  logic [3:0]  pwm_en;
  logic [7:0]  cfg_duty;
  logic [15:0] cfg_dessert;
  logic [7:0]  cfg_pnum;
  logic [31:0] cfg_pat;
  logic [3:0]  cfg_sel;
  logic        err_bad_ch;
  logic        err_timeout;
  logic [7:0]  drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  pwm_cmd_scheduler dut (
    .i_clk_50M     (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_ch      (cmd_ch),
    .i_cmd_duty    (cmd_duty),
    .i_cmd_dessert (cmd_dessert),
    .i_cmd_pnum    (cmd_pnum),
    .i_cmd_pat     (cmd_pat),
    .i_cmd_stop    (cmd_stop),
    .i_pwm_busy    (pwm_busy),
    .i_pwm_valid   (pwm_valid),
    .o_cmd_full    (cmd_full),
    .o_pwm_en      (pwm_en),
    .o_cfg_duty    (cfg_duty),
    .o_cfg_dessert (cfg_dessert),
    .o_cfg_pnum    (cfg_pnum),
    .o_cfg_pat     (cfg_pat),
    .o_cfg_sel     (cfg_sel),
    .o_err_bad_ch  (err_bad_ch),
    .o_err_timeout (err_timeout),
    .o_drop_cnt    (drop_cnt)
  );

  typedef struct {
    logic       v;
    logic [7:0] ch;
    logic [7:0] duty;
    logic [7:0] pnum;
    logic [3:0] busy;
    logic [3:0] pv;
    logic [3:0] x_en;
    logic [3:0] x_sel;
    logic [7:0] x_duty;
    logic [7:0] x_pnum;
    logic       x_bad;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0; cmd_dessert = '0;
    cmd_pnum = '0; cmd_pat = '0; cmd_stop = 1'b0; pwm_busy = '0; pwm_valid = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    #25;
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input logic [7:0] ch, input logic [7:0] duty, input logic [7:0] pnum,
                      input logic [15:0] dessert, input logic [31:0] pat);
    cmd_valid = 1'b1; cmd_ch = ch; cmd_duty = duty; cmd_pnum = pnum;
    cmd_dessert = dessert; cmd_pat = pat;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_en(input int ch, input logic val, input int budget, input string name);
    int i = 0;
    while (pwm_en[ch] !== val && i < budget) begin
      tick();
      i++;
    end
    chk(name, 64'(pwm_en[ch]), 64'(val));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst = 1'b1;
    #25;
    chk("rst en", 64'(pwm_en), 64'h0);
    chk("rst sel", 64'(cfg_sel), 64'h0);
    chk("rst cfg", {cfg_duty, cfg_pnum, cfg_dessert, cfg_pat[15:0]}, 64'h0);
    chk("rst flags", {61'h0, cmd_full, err_bad_ch, err_timeout}, 64'h0);
    chk("rst drop", 64'(drop_cnt), 64'h0);
    rst = 1'b0;
    tick();

    // Single command to idle channel 1, then bad channel indices.
    tbl[0]  = '{1'b1, 8'd1,   8'd8,  8'd3, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b0};
    tbl[3]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b0};
    tbl[4]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h2, 4'h2, 8'd8, 8'd3, 1'b0};
    tbl[5]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h2, 4'h0, 4'h2, 4'h2, 8'd8, 8'd3, 1'b0};
    tbl[6]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h2, 4'h2, 4'h0, 4'h2, 8'd8, 8'd3, 1'b0};
    tbl[7]  = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b0};
    tbl[8]  = '{1'b1, 8'd4,   8'h55, 8'd9, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b1};
    tbl[9]  = '{1'b1, 8'd5,   8'h66, 8'd9, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b1};
    tbl[10] = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b1};
    tbl[11] = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b1};
    tbl[12] = '{1'b0, 8'd0,   8'd0,  8'd0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8, 8'd3, 1'b1};

    for (int i = 0; i < 13; i++) begin
      cmd_valid = tbl[i].v; cmd_ch = tbl[i].ch; cmd_duty = tbl[i].duty;
      cmd_pnum = tbl[i].pnum; pwm_busy = tbl[i].busy; pwm_valid = tbl[i].pv;
      cmd_dessert = 16'h1234; cmd_pat = 32'hCAFEF00D;
      tick();
      chk($sformatf("vec%0d en", i), 64'(pwm_en), 64'(tbl[i].x_en));
      chk($sformatf("vec%0d sel", i), 64'(cfg_sel), 64'(tbl[i].x_sel));
      chk($sformatf("vec%0d cfg", i), {cfg_duty, cfg_pnum}, {tbl[i].x_duty, tbl[i].x_pnum});
      chk($sformatf("vec%0d bad", i), 64'(err_bad_ch), 64'(tbl[i].x_bad));
    end
    idle_in();

    // Queue fill while channel 0 stays busy, then drop counting and saturation.
    do_reset();
    pwm_busy = 4'b0001;
    send(8'd0, 8'd1, 8'd0, 16'd0, 32'd0);
    repeat (3) tick();
    cmd_valid = 1'b1; cmd_ch = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) chk("full after 3", 64'(cmd_full), 64'h0);
      if (k == 4) chk("full after 4", 64'(cmd_full), 64'h1);
      if (k == 4) chk("drop after 4", 64'(drop_cnt), 64'h0);
      if (k == 5) chk("drop after 5", 64'(drop_cnt), 64'h1);
    end
    cmd_valid = 1'b0;
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    chk("full after stop", 64'(cmd_full), 64'h0);
    chk("drop kept", 64'(drop_cnt), 64'h1);
    cmd_valid = 1'b1;
    repeat (300) tick();
    cmd_valid = 1'b0;
    chk("drop saturate", 64'(drop_cnt), 64'hFF);
    chk("full refilled", 64'(cmd_full), 64'h1);

    // Ack timeout on channel 3.
    do_reset();
    send(8'd3, 8'd9, 8'd2, 16'd0, 32'd0);
    wait_en(3, 1'b1, 10, "tmo en rise");
    repeat (14) tick();
    chk("tmo not yet", {62'h0, err_timeout, pwm_en[3]}, 64'h1);
    tick();
    chk("tmo fired", 64'(err_timeout), 64'h1);
    chk("tmo en clr", 64'(pwm_en), 64'h0);

    // Release and restart of an infinite-pulse channel.
    do_reset();
    chk("tmo cleared", 64'(err_timeout), 64'h0);
    send(8'd2, 8'h10, 8'd0, 16'd0, 32'd0);
    wait_en(2, 1'b1, 10, "ch2 first en");
    pwm_busy = 4'b0100;
    tick();
    send(8'd2, 8'h11, 8'd0, 16'hAAAA, 32'h11111111);
    send(8'd2, 8'h22, 8'd0, 16'hBBBB, 32'h22222222);
    wait_en(2, 1'b0, 10, "ch2 release A");
    repeat (3) tick();
    chk("ch2 held off", 64'(pwm_en), 64'h0);
    chk("ch2 cfg A", {cfg_duty, cfg_dessert}, {8'h11, 16'hAAAA});
    pwm_busy = 4'b0000;
    wait_en(2, 1'b1, 10, "ch2 restart A");
    pwm_busy = 4'b0100;
    wait_en(2, 1'b0, 10, "ch2 release B");
    chk("ch2 cfg B", {cfg_duty, cfg_pat}, {8'h22, 32'h22222222});
    pwm_busy = 4'b0000;
    wait_en(2, 1'b1, 10, "ch2 restart B");
    chk("ch2 sel", 64'(cfg_sel), 64'h4);
    pwm_busy = 4'b0100;
    tick();

    // Asynchronous reset while running.
    rst = 1'b1;
    #2;
    chk("async rst en", 64'(pwm_en), 64'h0);
    chk("async rst cfg", {cfg_duty, cfg_sel}, 64'h0);
    #30;
    rst = 1'b0;
    repeat (5) tick();
    chk("post rst en", 64'(pwm_en), 64'h0);

    // Stop with three queued commands and channel 0 running.
    do_reset();
    send(8'd0, 8'h40, 8'd0, 16'd0, 32'd0);
    wait_en(0, 1'b1, 10, "stop ch0 en");
    pwm_busy = 4'b0011;
    tick();
    cmd_valid = 1'b1; cmd_ch = 8'd1;
    repeat (4) tick();
    cmd_valid = 1'b0;
    chk("stop pre en", 64'(pwm_en), 64'h1);
    cmd_stop = 1'b1; cmd_valid = 1'b1; cmd_ch = 8'd3;
    tick();
    cmd_stop = 1'b0; cmd_valid = 1'b0;
    chk("stop en", 64'(pwm_en), 64'h0);
    chk("stop full", 64'(cmd_full), 64'h0);
    pwm_busy = 4'b0000;
    repeat (8) tick();
    chk("stop idle en", 64'(pwm_en), 64'h0);
    chk("stop idle sel", 64'(cfg_sel), 64'h2);
    send(8'd3, 8'h77, 8'd1, 16'd0, 32'd0);
    tick();
    tick();
    chk("post stop sel", {cfg_sel, cfg_duty}, {4'h8, 8'h77});
    tick();
    chk("post stop en early", 64'(pwm_en), 64'h0);
    tick();
    chk("post stop en", 64'(pwm_en), 64'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_cmd_scheduler.md
PWM_CMD_SCHEDULER -- requirements
Module: pwm_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter _NUM_CHANNELS, default 4, number of PWM channels scheduled.
REQ-002 The block SHALL have parameter _FIFO_DEPTH, default 4, command queue entries (power of 2).
REQ-003 The block SHALL have parameter _ACK_TIMEOUT, default 15, cycles allowed for a channel to raise busy after start.
REQ-004 Ports SHALL be:
- clk_50M  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  one-cycle command strobe (from pack_done).
- cmd_ch  in  8  target channel index.
- cmd_duty  in  8  duty cycle count.
- cmd_dessert  in  16  inter-pulse gap count.
- cmd_pnum  in  8  pulse count; 0 = infinite.
- cmd_pat  in  32  pattern word.
- cmd_stop  in  1  one-cycle strobe: flush queue, drop all pwm_en.
- pwm_busy  in  _NUM_CHANNELS  per-channel busy.
- pwm_valid  in  _NUM_CHANNELS  per-channel done pulse.
- cmd_full  out  1  queue full.
- pwm_en  out  _NUM_CHANNELS  per-channel enable level.
- cfg_duty / cfg_dessert / cfg_pnum / cfg_pat  out  8/16/8/32  config bus, held stable while any pwm_en bit is asserted for the latched channel.
- cfg_sel  out  _NUM_CHANNELS  one-hot channel owning the config bus.
- err_bad_ch  out  1  sticky: cmd_ch >= _NUM_CHANNELS received.
- err_timeout  out  1  sticky: ack timeout occurred.
- drop_cnt  out  8  saturating count of commands dropped while full.

Function
REQ-005 Command capture SHALL push {ch,duty,dessert,pnum,pat} into the FIFO on cmd_valid when not full and cmd_ch < _NUM_CHANNELS.
REQ-006 cmd_valid with full FIFO SHALL drop the command and increment drop_cnt, saturating at 255.
REQ-007 cmd_valid with cmd_ch >= _NUM_CHANNELS SHALL not push and SHALL set err_bad_ch.
REQ-008 cmd_full SHALL equal (FIFO count == _FIFO_DEPTH), registered, same cycle as count update.
REQ-009 FSM states SHALL be IDLE, LOAD, WAIT_FREE, START, ACK.
REQ-010 IDLE -> LOAD when FIFO non-empty; LOAD pops head and latches it to cfg_* and cfg_sel in one cycle.
REQ-011 LOAD -> WAIT_FREE; WAIT_FREE -> START on the first cycle pwm_busy[ch]==0 and pwm_en[ch]==0.
REQ-012 An already-running channel with pwm_en[ch]==1 SHALL be released (pwm_en[ch]<=0) in WAIT_FREE, then restarted once busy drops.
REQ-013 START SHALL set pwm_en[ch]<=1, -> ACK; pwm_en rises exactly 3 cycles after pop when the channel is idle.
REQ-014 ACK -> IDLE when pwm_busy[ch]==1; after _ACK_TIMEOUT cycles without busy, set err_timeout, clear pwm_en[ch], -> IDLE.
REQ-015 pwm_valid[k] SHALL clear pwm_en[k] next cycle for any k, in any state; finite-pulse channels thus self-release.
REQ-016 Simultaneous cmd_valid and pop SHALL both succeed; count unchanged.
REQ-017 cmd_stop SHALL, next cycle, empty the FIFO, clear all pwm_en, return to IDLE; cmd_valid in the same cycle is discarded.
REQ-018 cfg_* SHALL change only in LOAD.
REQ-019 FIFO pointers SHALL wrap modulo _FIFO_DEPTH.

Reset
REQ-020 On rst: state IDLE, FIFO empty, pwm_en=0, cfg_*=0, cfg_sel=0, cmd_full=0, err_bad_ch=0, err_timeout=0, drop_cnt=0.
REQ-021 rst mid-operation SHALL abort immediately; no pwm_en glitch after release.

Structure
REQ-022 State encoding, field widths and timeout default SHALL live in a shared package pwm_sched_pkg.
REQ-023 The queue SHALL be one sub-module, pwm_cmd_fifo (sync, show-ahead, count output).

Verification
REQ-024 Single command ch=1,duty=8,pnum=3 on idle channel -> pwm_en[1] high 3 cycles after pop, cfg_sel=4'b0010, cleared after pwm_valid[1].
REQ-025 Five cmd_valid back-to-back, busy held high on ch0 -> cmd_full=1 after 4, drop_cnt=1.
REQ-026 cmd_ch=5 -> err_bad_ch=1, FIFO count 0.
REQ-027 Channel never raises busy -> err_timeout=1 after 15 ACK cycles, pwm_en[ch]=0.
REQ-028 Two queued commands to ch2 while running pnum=0 -> pwm_en[2] dropped, reasserted with second cfg_* once busy falls.
REQ-029 cmd_stop with 3 queued and ch0 running -> FIFO empty, pwm_en=0 next cycle, state IDLE.
